// File: rtl/inst_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : inst_decode_stage
//  Purpose  : Registered instruction-decode stage for the 16-bit RISC core.
//             Splits the instruction into register fields, produces the
//             control flags and ALU control, sign-extends the offset,
//             computes branch/jump targets and holds back a consumer of a
//             just-accepted load for LU_BUBBLES cycles.
//  Ports    : clk, rst             clock, synchronous active-high reset
//             flush                drop held bundle and load-use state
//             in_valid/in_ready    fetch-side handshake (inst, pc)
//             out_valid/out_ready  execute-side handshake (decoded bundle)
//             rs1, rs2, rd         register fields (0 when unused)
//             imm, tgt             sign-extended offset, branch/jump target
//             alu_op, alu_ctl      ALU class and operation code
//             reg_dst .. jmp       control flags
//             illegal              opcode 1110/1111
//  Revision : 1.0  initial release
// ============================================================================
module inst_decode_stage #(
    parameter int WIDTH      = 16,
    parameter int PC_W       = 16,
    parameter int LU_BUBBLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      inst,
    input  logic [PC_W-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       rs1,
    output logic [2:0]       rs2,
    output logic [2:0]       rd,
    output logic [WIDTH-1:0] imm,
    output logic [PC_W-1:0]  tgt,
    output logic [1:0]       alu_op,
    output logic [3:0]       alu_ctl,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             m2r,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             beq,
    output logic             bne,
    output logic             jmp,
    output logic             illegal
);

    localparam int         c_bundle_w = 9 + WIDTH + PC_W + 2 + 4 + 10;
    localparam logic [1:0] c_bubbles  = 2'(LU_BUBBLES);

    localparam logic [3:0] c_op_ldr = 4'h0;
    localparam logic [3:0] c_op_str = 4'h1;
    localparam logic [3:0] c_op_beq = 4'hB;
    localparam logic [3:0] c_op_bne = 4'hC;
    localparam logic [3:0] c_op_jmp = 4'hD;

    // Instruction fields
    logic [3:0] w_opc;
    logic [2:0] w_f_rs1;
    logic [2:0] w_f_rwo;
    logic [2:0] w_f_rd;
    assign w_opc   = inst[15:12];
    assign w_f_rs1 = inst[11:9];
    assign w_f_rwo = inst[8:6];
    assign w_f_rd  = inst[5:3];

    // Offsets and targets
    logic [WIDTH-1:0] w_sext6;
    logic [PC_W-1:0]  w_br_off;
    logic [PC_W-1:0]  w_br_tgt;
    logic [PC_W-1:0]  w_jmp_tgt;
    assign w_sext6   = {{(WIDTH-6){inst[5]}}, inst[5:0]};
    // Word offset scaled to bytes, already in PC width so the add wraps.
    assign w_br_off  = {{(PC_W-7){inst[5]}}, inst[5:0], 1'b0};
    assign w_br_tgt  = pc + PC_W'(2) + w_br_off;
    assign w_jmp_tgt = {pc[PC_W-1:13], inst[11:0], 1'b0};

    // Decoded bundle (combinational)
    logic [2:0]       w_rs1, w_rs2, w_rd;
    logic [WIDTH-1:0] w_imm;
    logic [PC_W-1:0]  w_tgt;
    logic [1:0]       w_alu_op;
    logic [3:0]       w_alu_ctl;
    logic             w_reg_dst, w_alu_src, w_m2r, w_reg_write;
    logic             w_mem_read, w_mem_write, w_beq, w_bne, w_jmp, w_illegal;
    logic             w_use_rs1, w_use_rwo;

    always_comb begin
        w_rs1       = '0;
        w_rs2       = '0;
        w_rd        = '0;
        w_imm       = '0;
        w_tgt       = '0;
        w_alu_op    = 2'b00;
        w_alu_ctl   = 4'b0000;
        w_reg_dst   = 1'b0;
        w_alu_src   = 1'b0;
        w_m2r       = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_beq       = 1'b0;
        w_bne       = 1'b0;
        w_jmp       = 1'b0;
        w_illegal   = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rwo   = 1'b0;
        case (w_opc)
            c_op_ldr: begin
                w_rs1       = w_f_rs1;
                w_rd        = w_f_rwo;
                w_imm       = w_sext6;
                w_alu_src   = 1'b1;
                w_m2r       = 1'b1;
                w_reg_write = 1'b1;
                w_mem_read  = 1'b1;
                w_alu_op    = 2'b10;
                w_use_rs1   = 1'b1;
            end
            c_op_str: begin
                w_rs1       = w_f_rs1;
                w_rs2       = w_f_rwo;
                w_imm       = w_sext6;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
                w_alu_op    = 2'b10;
                w_use_rs1   = 1'b1;
                w_use_rwo   = 1'b1;
            end
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
                w_rs1       = w_f_rs1;
                w_rs2       = w_f_rwo;
                w_rd        = w_f_rd;
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
                // ADD..SLT map to 0..7 and HMD (1010) lands on 1000.
                w_alu_ctl   = w_opc - 4'd2;
                w_use_rs1   = 1'b1;
                w_use_rwo   = 1'b1;
            end
            c_op_beq, c_op_bne: begin
                w_rs1     = w_f_rs1;
                w_rs2     = w_f_rwo;
                w_imm     = w_sext6;
                w_tgt     = w_br_tgt;
                w_beq     = (w_opc == c_op_beq);
                w_bne     = (w_opc == c_op_bne);
                w_alu_op  = 2'b01;
                w_alu_ctl = 4'b0001;
                w_use_rs1 = 1'b1;
                w_use_rwo = 1'b1;
            end
            c_op_jmp: begin
                w_jmp = 1'b1;
                w_tgt = w_jmp_tgt;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    logic [c_bundle_w-1:0] w_bundle;
    assign w_bundle = {w_rs1, w_rs2, w_rd, w_imm, w_tgt, w_alu_op, w_alu_ctl,
                       w_reg_dst, w_alu_src, w_m2r, w_reg_write, w_mem_read,
                       w_mem_write, w_beq, w_bne, w_jmp, w_illegal};

    // Handshake and load-use tracking
    logic                  r_out_valid;
    logic [c_bundle_w-1:0] r_bundle;
    logic                  r_ld_v;
    logic [2:0]            r_ld_rd;
    logic [1:0]            r_cnt;
    logic                  w_hazard;
    logic                  w_accept;

    // Only raised while no stall is already running, so the counter loads
    // once per consumer; the detection cycle is the first lost cycle.
    assign w_hazard = in_valid && r_ld_v && (LU_BUBBLES != 0) && (r_cnt == 2'd0) &&
                      ((w_use_rs1 && (w_f_rs1 == r_ld_rd)) ||
                       (w_use_rwo && (w_f_rwo == r_ld_rd)));

    assign in_ready = !rst && !flush && (r_cnt == 2'd0) && !w_hazard &&
                      (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_bundle    <= '0;
            r_ld_v      <= 1'b0;
            r_ld_rd     <= 3'd0;
            r_cnt       <= 2'd0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_ld_v      <= 1'b0;
            r_cnt       <= 2'd0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_bundle    <= w_bundle;
            r_ld_v      <= (w_opc == c_op_ldr);
            r_ld_rd     <= w_f_rwo;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            // Dropping ld_v when the stall has run its course lets the
            // waiting consumer through on the following cycle.
            if (w_hazard) begin
                r_cnt <= c_bubbles - 2'd1;
                if (c_bubbles == 2'd1) begin
                    r_ld_v <= 1'b0;
                end
            end else if (r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
                if (r_cnt == 2'd1) begin
                    r_ld_v <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign {rs1, rs2, rd, imm, tgt, alu_op, alu_ctl,
            reg_dst, alu_src, m2r, reg_write, mem_read,
            mem_write, beq, bne, jmp, illegal} = r_bundle;

endmodule
`default_nettype wire

// File: tb/tb_inst_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_decode_stage
//  Purpose  : Self-checking bench for inst_decode_stage (WIDTH=32, PC_W=16,
//             LU_BUBBLES=2): directed scenarios followed by random traffic,
//             all compared against a cycle-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_decode_stage;

    localparam int c_width = 32;
    localparam int c_pc_w  = 16;
    localparam int c_n     = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [15:0]        inst = '0;
    logic [c_pc_w-1:0]  pc = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [2:0]         rs1, rs2, rd;
    logic [c_width-1:0] imm;
    logic [c_pc_w-1:0]  tgt;
    logic [1:0]         alu_op;
    logic [3:0]         alu_ctl;
    logic               reg_dst, alu_src, m2r, reg_write, mem_read, mem_write;
    logic               beq, bne, jmp, illegal;

    always #5 clk = ~clk;

    inst_decode_stage #(
        .WIDTH     (c_width),
        .PC_W      (c_pc_w),
        .LU_BUBBLES(c_n)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inst     (inst),
        .pc       (pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .imm      (imm),
        .tgt      (tgt),
        .alu_op   (alu_op),
        .alu_ctl  (alu_ctl),
        .reg_dst  (reg_dst),
        .alu_src  (alu_src),
        .m2r      (m2r),
        .reg_write(reg_write),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .beq      (beq),
        .bne      (bne),
        .jmp      (jmp),
        .illegal  (illegal)
    );

    logic [72:0] dut_bundle;
    assign dut_bundle = {rs1, rs2, rd, imm, tgt, alu_op, alu_ctl,
                         reg_dst, alu_src, m2r, reg_write, mem_read,
                         mem_write, beq, bne, jmp, illegal};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode from the instruction-set tables.
    function automatic logic [72:0] ref_decode(input logic [15:0] i, input logic [15:0] p);
        int          opc;
        int          off;
        logic [2:0]  r1, r2, rdv;
        logic [31:0] im;
        logic [15:0] tg;
        logic [1:0]  aop;
        logic [3:0]  actl;
        logic        f_dst, f_src, f_m2r, f_rw, f_mr, f_mw, f_beq, f_bne, f_jmp, f_ill;
        opc = int'(i[15:12]);
        off = int'(i[5:0]);
        if (off >= 32) off = off - 64;
        r1 = 0; r2 = 0; rdv = 0; im = 0; tg = 0; aop = 0; actl = 0;
        {f_dst, f_src, f_m2r, f_rw, f_mr, f_mw, f_beq, f_bne, f_jmp, f_ill} = '0;
        if (opc == 0) begin
            r1 = i[11:9]; rdv = i[8:6]; im = 32'(off);
            f_src = 1; f_m2r = 1; f_rw = 1; f_mr = 1; aop = 2'b10;
        end else if (opc == 1) begin
            r1 = i[11:9]; r2 = i[8:6]; im = 32'(off);
            f_src = 1; f_mw = 1; aop = 2'b10;
        end else if (opc >= 2 && opc <= 10) begin
            r1 = i[11:9]; r2 = i[8:6]; rdv = i[5:3];
            f_dst = 1; f_rw = 1; actl = 4'(opc - 2);
        end else if (opc == 11 || opc == 12) begin
            r1 = i[11:9]; r2 = i[8:6]; im = 32'(off);
            tg = 16'((int'(p) + 2 + off * 2) % 65536);
            f_beq = (opc == 11); f_bne = (opc == 12);
            aop = 2'b01; actl = 4'b0001;
        end else if (opc == 13) begin
            f_jmp = 1;
            tg = 16'((int'(p) / 8192) * 8192 + int'(i[11:0]) * 2);
        end else begin
            f_ill = 1;
        end
        return {r1, r2, rdv, im, tg, aop, actl,
                f_dst, f_src, f_m2r, f_rw, f_mr, f_mw, f_beq, f_bne, f_jmp, f_ill};
    endfunction

    // Does instruction i read register r (load-use sense)?
    function automatic bit reads_reg(input logic [15:0] i, input logic [2:0] r);
        int opc;
        opc = int'(i[15:12]);
        if (opc <= 12 && i[11:9] == r) return 1;
        if (opc >= 1 && opc <= 12 && i[8:6] == r) return 1;
        return 0;
    endfunction

    // Model state
    bit          m_known = 0;
    bit          m_ov = 0;
    logic [72:0] m_bundle = '0;
    bit          m_ldv = 0;
    logic [2:0]  m_ldrd = 0;
    int          m_stall = 0;     // stall cycles still to come after this one
    bit          obs_ready = 0;
    bit          last_accept = 0;

    task automatic step(input logic r, input logic f, input logic v,
                        input logic [15:0] i, input logic [15:0] p, input logic ordy);
        bit haz, exp_ready, acc;
        rst = r; flush = f; in_valid = v; inst = i; pc = p; out_ready = ordy;
        #2;
        haz = v && m_ldv && (c_n > 0) && (m_stall == 0) && reads_reg(i, m_ldrd);
        exp_ready = !r && !f && (m_stall == 0) && !haz && (!m_ov || ordy);
        acc = v && exp_ready;
        obs_ready = in_ready;
        if (m_known) begin
            check("in_ready", 96'(in_ready), 96'(exp_ready));
            check("out_valid", 96'(out_valid), 96'(m_ov));
            if (m_ov) check("bundle", 96'(dut_bundle), 96'(m_bundle));
        end
        if (r) begin
            m_ov = 0; m_bundle = '0; m_ldv = 0; m_ldrd = 0; m_stall = 0; m_known = 1;
        end else if (f) begin
            m_ov = 0; m_ldv = 0; m_stall = 0;
        end else if (acc) begin
            m_ov = 1; m_bundle = ref_decode(i, p);
            m_ldv = (i[15:12] == 4'h0); m_ldrd = i[8:6];
        end else begin
            if (m_ov && ordy) m_ov = 0;
            if (haz) begin
                m_stall = c_n - 1;
                if (m_stall == 0) m_ldv = 0;
            end else if (m_stall > 0) begin
                m_stall--;
                if (m_stall == 0) m_ldv = 0;
            end
        end
        last_accept = acc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] gen_inst();
        logic [3:0] opc;
        logic [1:0] a, b;
        logic [5:0] lo;
        opc = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom_range(0, 15));
        a   = 2'($urandom_range(0, 3));
        b   = 2'($urandom_range(0, 3));
        lo  = 6'($urandom);
        return {opc, 1'b0, a, 1'b0, b, lo};
    endfunction

    initial begin
        int          n_stall;
        bit          got;
        bit          cur_v;
        logic [15:0] cur_i, cur_p;
        logic        r, f, ordy;

        @(posedge clk);
        #1;
        // Reset
        step(1, 0, 0, 16'h0000, 16'h0000, 1);
        check("rst_out_valid", 96'(out_valid), 96'(0));
        check("rst_bundle", 96'(dut_bundle), 96'(0));

        // ADD, then LDR with negative offset
        step(0, 0, 1, 16'h2298, 16'h0100, 1);
        check("add_ctl", 96'({reg_dst, reg_write, alu_ctl, imm}), 96'({1'b1, 1'b1, 4'b0000, 32'h0}));
        step(0, 0, 1, 16'h02BF, 16'h0102, 1);
        check("ldr_imm", 96'(imm), 96'(32'hFFFF_FFFF));
        check("ldr_flags", 96'({mem_read, m2r, alu_src, reg_write, alu_op}), 96'({4'b1111, 2'b10}));

        // Load-use: ADD reading r2 right after LDR writing r2
        n_stall = 0; got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            step(0, 0, 1, 16'h2418, 16'h0104, 1);
            if (obs_ready) got = 1; else n_stall++;
        end
        check("lu_accepted", 96'(got), 96'(1));
        check("lu_stall_cycles", 96'(n_stall), 96'(c_n));

        // LDR then an independent ADD: no stall
        step(0, 0, 1, 16'h02BF, 16'h0106, 1);
        step(0, 0, 1, 16'h2658, 16'h0108, 1);
        check("no_stall", 96'(obs_ready), 96'(1));

        // Branch and jump targets
        step(0, 0, 1, 16'hB23E, 16'h0010, 1);
        check("beq_tgt", 96'({beq, alu_op, tgt}), 96'({1'b1, 2'b01, 16'h000E}));
        step(0, 0, 1, 16'hD005, 16'hE000, 1);
        check("jmp_tgt", 96'({jmp, tgt}), 96'({1'b1, 16'hE00A}));

        // Illegal opcode and HMD
        step(0, 0, 1, 16'hF000, 16'h0200, 1);
        check("illegal", 96'({illegal, dut_bundle[9:1], imm, tgt}), 96'({1'b1, 9'b0, 32'h0, 16'h0}));
        step(0, 0, 1, 16'hA298, 16'h0202, 1);
        check("hmd_ctl", 96'(alu_ctl), 96'(4'b1000));

        // Backpressure: hold out_ready low 3 cycles with a new input waiting
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 16'h3298, 16'h0204, 0);
            check("bp_in_ready", 96'(obs_ready), 96'(0));
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 16'h4298 + 16'(k), 16'h0206 + 16'(2 * k), 1);
            check("bp_resume", 96'(obs_ready), 96'(1));
        end

        // Flush during a load-use stall
        step(0, 0, 1, 16'h02BF, 16'h0300, 1);
        step(0, 0, 1, 16'h2418, 16'h0302, 1);
        step(0, 1, 1, 16'h2418, 16'h0302, 1);
        check("flush_out_valid", 96'(out_valid), 96'(0));
        step(0, 0, 1, 16'h2418, 16'h0302, 1);
        check("flush_accept", 96'(obs_ready), 96'(1));

        // Reset in the middle of a stall
        step(0, 0, 1, 16'h02BF, 16'h0400, 1);
        step(0, 0, 1, 16'h2418, 16'h0402, 1);
        step(1, 0, 1, 16'h2418, 16'h0402, 1);
        step(0, 0, 1, 16'h2418, 16'h0402, 1);
        check("rst_stall_accept", 96'(obs_ready), 96'(1));

        // Random traffic
        cur_v = 0; cur_i = '0; cur_p = '0;
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 199) == 0);
            f    = ($urandom_range(0, 39) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            if (!cur_v || last_accept) begin
                cur_v = ($urandom_range(0, 4) != 0);
                cur_i = gen_inst();
                cur_p = 16'($urandom);
            end
            step(r, f, cur_v, cur_i, cur_p, ordy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
